// File: rtl/cpu_seq_if.sv
// Handshake bundle between the instruction sequencer and the CPU datapath.
// The slave side is the sequencer; the master side supplies ena/opcode/zero.
interface cpu_seq_if #(
  parameter int OPW = 3
);
  logic           ena;
  logic [OPW-1:0] opcode;
  logic           zero;
  logic [2:0]     phase;
  logic           fetch;
  logic           rd;
  logic           wr;
  logic           load_ir;
  logic           inc_pc;
  logic           load_pc;
  logic           load_acc;
  logic           datactl_ena;
  logic           halt;

  modport master (
    output ena, opcode, zero,
    input  phase, fetch, rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena, halt
  );

  modport slave (
    input  ena, opcode, zero,
    output phase, fetch, rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena, halt
  );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// 8-phase instruction sequencer: every strobe is registered and valid in the cycle its phase is shown.
// No backpressure; ena is only looked at on instruction boundaries, HALTED is left only through reset.
module cpu_seq_ctrl #(
  parameter int PHASES = 8,
  parameter int OPW    = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  cpu_seq_if.slave  bus
);

  localparam logic [2:0]     LAST   = 3'(PHASES - 1);
  localparam logic [OPW-1:0] OP_HLT = OPW'(0);
  localparam logic [OPW-1:0] OP_SKZ = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_AND = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4);
  localparam logic [OPW-1:0] OP_LDA = OPW'(5);
  localparam logic [OPW-1:0] OP_STO = OPW'(6);
  localparam logic [OPW-1:0] OP_JMP = OPW'(7);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  typedef struct packed {
    logic fetch;
    logic rd;
    logic wr;
    logic load_ir;
    logic inc_pc;
    logic load_pc;
    logic load_acc;
    logic datactl_ena;
    logic halt;
  } strobe_t;

  localparam strobe_t HALT_ST = strobe_t'(9'b0_0000_0001);

  state_t     state;
  logic [2:0] phase;
  strobe_t    st;

  // Strobes for the phase about to be entered, from the inputs seen at that edge.
  function automatic strobe_t decode(input logic [2:0] ph, input logic [OPW-1:0] op, input logic z);
    strobe_t s;
    logic    alu;
    logic    sto;
    logic    jmp;
    logic    skz;
    alu = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    sto = (op == OP_STO);
    jmp = (op == OP_JMP);
    skz = (op == OP_SKZ);
    s = '0;
    s.fetch = ~ph[2];
    case (ph)
      3'd0: begin
        s.rd      = 1'b1;
        s.load_ir = 1'b1;
      end
      3'd1: begin
        s.rd      = 1'b1;
        s.load_ir = 1'b1;
        s.inc_pc  = 1'b1;
      end
      3'd3: begin
        s.inc_pc = 1'b1;
        s.halt   = (op == OP_HLT);
      end
      3'd4: begin
        s.rd          = alu;
        s.load_pc     = jmp;
        s.datactl_ena = sto;
      end
      3'd5: begin
        s.rd          = alu;
        s.load_acc    = alu;
        s.load_pc     = jmp;
        s.inc_pc      = jmp | (skz & z);
        s.wr          = sto;
        s.datactl_ena = sto;
      end
      3'd6: begin
        s.rd          = alu;
        s.datactl_ena = sto;
      end
      3'd7: s.inc_pc = skz & z;
      default: ;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= 3'd0;
      st    <= '0;
    end else begin
      case (state)
        IDLE: begin
          phase <= 3'd0;
          if (bus.ena) begin
            state <= RUN;
            st    <= decode(3'd0, bus.opcode, bus.zero);
          end else begin
            st <= '0;
          end
        end
        RUN: begin
          // The halt strobe shown in phase 3 is the registered HLT decision; reuse it.
          if (phase == 3'd3 && st.halt) begin
            state <= HALTED;
            st    <= HALT_ST;
          end else if (phase == LAST) begin
            phase <= 3'd0;
            if (bus.ena) begin
              st <= decode(3'd0, bus.opcode, bus.zero);
            end else begin
              state <= IDLE;
              st    <= '0;
            end
          end else begin
            phase <= phase + 3'd1;
            st    <= decode(phase + 3'd1, bus.opcode, bus.zero);
          end
        end
        HALTED: begin
          phase <= 3'd3;
          st    <= HALT_ST;
        end
        default: begin
          state <= IDLE;
          phase <= 3'd0;
          st    <= '0;
        end
      endcase
    end
  end

  assign bus.phase       = phase;
  assign bus.fetch       = st.fetch;
  assign bus.rd          = st.rd;
  assign bus.wr          = st.wr;
  assign bus.load_ir     = st.load_ir;
  assign bus.inc_pc      = st.inc_pc;
  assign bus.load_pc     = st.load_pc;
  assign bus.load_acc    = st.load_acc;
  assign bus.datactl_ena = st.datactl_ena;
  assign bus.halt        = st.halt;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: stimulus pushes the expected per-cycle output word,
// a monitor pops one entry after every rising edge and compares it with the DUT.
module tb_cpu_seq_ctrl;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;
  localparam logic [11:0] IDLE_V = 12'd0;
  localparam logic [11:0] HALT_V = {3'd3, 9'b0_0000_0001};

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [11:0] q[$];
  bit   halted;

  cpu_seq_if #(.OPW(3)) bus ();

  cpu_seq_ctrl #(.PHASES(8), .OPW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output word: {phase, fetch, rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena, halt}
  function automatic logic [11:0] dut_vec();
    return {bus.phase, bus.fetch, bus.rd, bus.wr, bus.load_ir, bus.inc_pc,
            bus.load_pc, bus.load_acc, bus.datactl_ena, bus.halt};
  endfunction

  // Reference: which strobes an opcode asserts in a given phase, from the phase/opcode table.
  function automatic logic [11:0] exp_vec(input int ph, input logic [2:0] op, input logic z);
    logic alu, f, r, w, li, ip, lp, la, dc, h;
    alu = (op == ADD) || (op == 3'd3) || (op == 3'd4) || (op == LDA);
    f  = (ph < 4);
    r  = (ph < 2) || (alu && ph >= 4 && ph <= 6);
    w  = (op == STO) && (ph == 5);
    li = (ph < 2);
    ip = (ph == 1) || (ph == 3) || ((op == JMP) && ph == 5) ||
         ((op == SKZ) && z && (ph == 5 || ph == 7));
    lp = (op == JMP) && (ph == 4 || ph == 5);
    la = alu && (ph == 5);
    dc = (op == STO) && (ph >= 4 && ph <= 6);
    h  = (op == HLT) && (ph == 3);
    return {3'(ph), f, r, w, li, ip, lp, la, dc, h};
  endfunction

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  // Monitor: one scoreboard entry per rising edge while stimulus is active.
  initial begin
    logic [11:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("cycle_cmp", dut_vec(), e);
        checks++;
        if ((bus.rd && bus.wr) || (bus.wr && !bus.datactl_ena) ||
            (bus.load_ir && !bus.fetch) || (bus.load_pc && !bus.phase[2])) begin
          errors++;
          $display("FAIL invariant at %0t: got %b", $time, dut_vec());
        end
      end
    end
  end

  task automatic idle_n(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.ena = 1'b0;
      bus.opcode = 3'($urandom);
      bus.zero = 1'($urandom);
      q.push_back(IDLE_V);
    end
  endtask

  task automatic start();
    @(negedge clk);
    bus.ena = 1'b1;
    bus.opcode = 3'($urandom);
    bus.zero = 1'($urandom);
    q.push_back(exp_vec(0, 3'd0, 1'b0));
  endtask

  task automatic halted_n(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.ena = 1'b1;
      bus.opcode = 3'($urandom);
      bus.zero = 1'($urandom);
      q.push_back(HALT_V);
    end
  endtask

  // Reset asserted just after an edge, checked before the next one, then released.
  task automatic rst_async(input string name);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk(name, dut_vec(), IDLE_V);
    @(negedge clk);
    bus.ena = 1'b1;
    q.push_back(IDLE_V);
    @(negedge clk);
    rst_n = 1'b1;
    bus.ena = 1'b0;
    q.push_back(IDLE_V);
  endtask

  // Phases 1..7 of an instruction whose P0 is already queued; ena in P0-P6 is random noise.
  task automatic do_instr(input logic [2:0] op, input logic z5, input logic z7,
                          input logic nxt, input int abort_ph, output bit hlt);
    hlt = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      bus.ena = 1'($urandom);
      bus.opcode = (k == 1) ? 3'($urandom) : op;
      bus.zero = (k == 5) ? z5 : (k == 7) ? z7 : 1'($urandom);
      q.push_back(exp_vec(k, op, bus.zero));
      if (k == abort_ph) begin
        rst_async("abort_reset");
        return;
      end
      if (op == HLT && k == 3) begin
        hlt = 1'b1;
        return;
      end
    end
    @(negedge clk);
    bus.ena = nxt;
    bus.opcode = 3'($urandom);
    bus.zero = 1'($urandom);
    q.push_back(nxt ? exp_vec(0, 3'd0, 1'b0) : IDLE_V);
  endtask

  initial begin
    bit running;
    logic nxt;
    rst_n = 1'b0;
    bus.ena = 1'b0;
    bus.opcode = 3'd0;
    bus.zero = 1'b0;
    #23;
    chk("reset_state", dut_vec(), IDLE_V);
    @(negedge clk);
    rst_n = 1'b1;
    q.push_back(IDLE_V);
    idle_n(2);

    start();
    do_instr(LDA, 1'($urandom), 1'($urandom), 1'b1, 0, halted);
    do_instr(ADD, 1'($urandom), 1'($urandom), 1'b1, 0, halted);
    do_instr(STO, 1'($urandom), 1'($urandom), 1'b1, 0, halted);
    do_instr(SKZ, 1'b1, 1'b1, 1'b1, 0, halted);
    do_instr(SKZ, 1'b0, 1'b0, 1'b1, 0, halted);
    do_instr(SKZ, 1'b1, 1'b0, 1'b1, 0, halted);
    do_instr(SKZ, 1'b0, 1'b1, 1'b0, 0, halted);
    idle_n(2);

    running = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!running) start();
      nxt = ($urandom_range(0, 3) != 0);
      do_instr(3'($urandom_range(1, 7)), 1'($urandom), 1'($urandom), nxt, 0, halted);
      running = nxt;
      if (!nxt) idle_n($urandom_range(0, 2));
    end
    if (running) begin
      do_instr(LDA, 1'b0, 1'b0, 1'b0, 0, halted);
    end

    start();
    do_instr(STO, 1'b0, 1'b0, 1'b1, 5, halted);
    idle_n(1);

    start();
    do_instr(JMP, 1'($urandom), 1'($urandom), 1'b1, 0, halted);
    do_instr(HLT, 1'($urandom), 1'($urandom), 1'b1, 0, halted);
    halted_n(22);
    rst_async("halt_reset");
    idle_n(1);

    start();
    do_instr(ADD, 1'b0, 1'b0, 1'b0, 0, halted);
    idle_n(2);

    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
